// File: rtl/wb_regfile.sv
// wb_regfile: writeback register file with write-first bypass, async reset, and retire/last-write tracking.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] RDIn,
  input  logic [DATA_W-1:0] ALUIn,
  input  logic [ADDR_W-1:0] wn,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       retire_cnt,
  output logic [ADDR_W-1:0] last_wn,
  output logic [DATA_W-1:0] last_data,
  output logic              last_valid
);
  localparam int N = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs_q [N];
  logic [31:0]       retire_cnt_q, retire_cnt_d;
  logic [ADDR_W-1:0] last_wn_q, last_wn_d;
  logic [DATA_W-1:0] last_data_q, last_data_d;
  logic              last_valid_q, last_valid_d;
  logic              commit;
  always_comb begin
    wb_data      = MemtoReg ? RDIn : ALUIn;
    commit       = RegWrite && (wn != '0);
    rd_a         = rst ? '0 : (commit && rs == wn) ? wb_data : (rs == '0) ? '0 : regs_q[rs];
    rd_b         = rst ? '0 : (commit && rt == wn) ? wb_data : (rt == '0) ? '0 : regs_q[rt];
    retire_cnt_d = RegWrite ? retire_cnt_q + 32'd1 : retire_cnt_q;
    last_wn_d    = commit ? wn : last_wn_q;
    last_data_d  = commit ? wb_data : last_data_q;
    last_valid_d = commit | last_valid_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
      retire_cnt_q <= '0;
      last_wn_q    <= '0;
      last_data_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      if (commit) regs_q[wn] <= wb_data;
      retire_cnt_q <= retire_cnt_d;
      last_wn_q    <= last_wn_d;
      last_data_q  <= last_data_d;
      last_valid_q <= last_valid_d;
    end
  end
  assign retire_cnt = retire_cnt_q;
  assign last_wn    = last_wn_q;
  assign last_data  = last_data_q;
  assign last_valid = last_valid_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile; expected state is queued at drive time and checked after the edge.
module tb_wb_regfile;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N = 2 ** AW;
  typedef struct {
    logic [31:0]   cnt;
    logic [AW-1:0] lwn;
    logic [DW-1:0] ld;
    logic          lv;
  } st_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] RDIn = '0, ALUIn = '0;
  logic [AW-1:0] wn = '0, rs = '0, rt = '0;
  logic RegWrite = 1'b0, MemtoReg = 1'b0;
  logic [DW-1:0] rd_a, rd_b, wb_data, last_data;
  logic [31:0] retire_cnt;
  logic [AW-1:0] last_wn;
  logic last_valid;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] m [N];
  st_t ms;
  st_t exp_q [$];
  wb_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .RDIn(RDIn), .ALUIn(ALUIn), .wn(wn), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .rs(rs), .rt(rt), .rd_a(rd_a), .rd_b(rd_b), .wb_data(wb_data),
    .retire_cnt(retire_cnt), .last_wn(last_wn), .last_data(last_data), .last_valid(last_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] rexp(input logic we, input logic [AW-1:0] w,
                                         input logic [DW-1:0] wb, input logic [AW-1:0] a);
    return (we && w != 0 && a == w) ? wb : (a == 0) ? '0 : m[a];
  endfunction
  task automatic clear_model();
    for (int i = 0; i < N; i++) m[i] = '0;
    ms = '{cnt: '0, lwn: '0, ld: '0, lv: 1'b0};
  endtask
  task automatic step(input logic we, input logic m2r, input logic [AW-1:0] w,
                      input logic [DW-1:0] rdv, input logic [DW-1:0] alu,
                      input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [DW-1:0] wbx;
    st_t e;
    @(negedge clk);
    RegWrite = we; MemtoReg = m2r; wn = w; RDIn = rdv; ALUIn = alu; rs = a; rt = b;
    #1;
    wbx = m2r ? rdv : alu;
    chk("wb_data", wb_data, wbx);
    chk("rd_a", rd_a, rexp(we, w, wbx, a));
    chk("rd_b", rd_b, rexp(we, w, wbx, b));
    if (we) ms.cnt = ms.cnt + 1;
    if (we && w != 0) begin
      m[w] = wbx;
      ms.lwn = w; ms.ld = wbx; ms.lv = 1'b1;
    end
    exp_q.push_back(ms);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("retire_cnt", retire_cnt, e.cnt);
    chk("last_wn", last_wn, e.lwn);
    chk("last_data", last_data, e.ld);
    chk("last_valid", last_valid, e.lv);
  endtask
  initial begin
    clear_model();
    @(negedge clk);
    #1;
    chk("rst_rd_a", rd_a, 0);
    chk("rst_cnt", retire_cnt, 0);
    chk("rst_valid", last_valid, 0);
    RegWrite = 1; wn = 4; ALUIn = 32'h55; rs = 4;
    #1;
    chk("rst_no_bypass", rd_a, 0);
    @(posedge clk);
    #1;
    chk("rst_write_dropped_cnt", retire_cnt, 0);
    @(negedge clk);
    rst = 0; RegWrite = 0;
    // write at reg 5, then read back through storage
    step(1, 0, 5, 32'h0, 32'h1234, 5, 0);
    step(0, 0, 0, 32'h0, 32'h0, 5, 5);
    step(1, 1, 7, 32'hDEADBEEF, 32'h0, 7, 7);
    step(0, 0, 0, 32'h0, 32'h0, 7, 5);
    step(1, 0, 0, 32'h0, 32'hFFFF, 0, 7);
    step(0, 0, 0, 32'h0, 32'h0, 0, 0);
    step(1, 0, 9, 32'h0, 32'h1, 9, 3);
    step(1, 0, 9, 32'h0, 32'h2, 9, 9);
    step(0, 1, 9, 32'h77, 32'h0, 9, 0);
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, N - 1)),
           $urandom, $urandom, AW'($urandom_range(0, N - 1)), AW'($urandom_range(0, N - 1)));
    step(1, 0, 3, 32'h0, 32'hA, 3, 0);
    @(negedge clk);
    RegWrite = 1; wn = 6; ALUIn = 32'h66; rs = 3; rt = 6;
    #2;
    rst = 1;
    #1;
    chk("async_rd_a", rd_a, 0);
    chk("async_rd_b", rd_b, 0);
    chk("async_cnt", retire_cnt, 0);
    chk("async_valid", last_valid, 0);
    chk("async_lwn", last_wn, 0);
    @(posedge clk);
    #1;
    chk("async_hold_cnt", retire_cnt, 0);
    @(negedge clk);
    rst = 0; RegWrite = 0;
    clear_model();
    for (int i = 0; i < N; i += 2) step(0, 0, 0, 32'h0, 32'h0, AW'(i), AW'(i + 1));
    step(1, 0, 12, 32'h0, 32'hBEE, 12, 12);
    @(negedge clk);
    RegWrite = 0;
    force dut.retire_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.retire_cnt_q;
    #1;
    chk("preload_cnt", retire_cnt, 32'hFFFFFFFF);
    ms.cnt = 32'hFFFFFFFF;
    step(1, 0, 2, 32'h0, 32'h22, 2, 12);
    step(0, 0, 0, 32'h0, 32'h0, 2, 12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
